cpu_run_ctrl: RTL

//  Host-side run controller for the 9-bit-instruction CPU core: the driving end of the core's start/halt interface.

---
 rtl/cpu_run_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Host-side run controller for the 9-bit-instruction CPU core: pulses start, waits for halt, reports done and cycle count.
// Optional watchdog abort is compiled in when CPU_WATCHDOG_EN is defined.
module cpu_run_ctrl #(
  parameter int INSTR_ADDR_W   = 9,
  parameter int CNT_W          = 16,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [INSTR_ADDR_W-1:0] start_addr_in,
  input  logic                    halt,
  output logic                    start,
  output logic [INSTR_ADDR_W-1:0] start_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    timed_out,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [1:0]              state_dbg
);

  // Handshake: go is a one-cycle request honoured only in IDLE; done is a one-cycle
  // completion pulse and there is no back-pressure from the host.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_W-1:0]  START_LAST = SC_W'(START_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_ONE     = SC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  generate
    if (START_CYCLES < 1) begin : g_bad_start_cycles
      $error("cpu_run_ctrl: START_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_timeout
      $error("cpu_run_ctrl: TIMEOUT_CYCLES out of range for CNT_W");
    end
  endgenerate

`ifdef CPU_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
`endif

  state_t          state;
  logic [SC_W-1:0] start_cnt;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      start_cnt   <= '0;
      start       <= 1'b0;
      start_addr  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (go) begin
            start_addr  <= start_addr_in;
            cycle_count <= '0;
            timed_out   <= 1'b0;
            start_cnt   <= '0;
            start       <= 1'b1;
            busy        <= 1'b1;
            state       <= S_START;
          end
        end

        // Halt is deliberately not looked at here: it may still be high from the previous program.
        S_START: begin
          if (start_cnt == START_LAST) begin
            start <= 1'b0;
            state <= S_RUN;
          end else begin
            start_cnt <= start_cnt + SC_ONE;
          end
        end

        S_RUN: begin
          if (halt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
`ifdef CPU_WATCHDOG_EN
          // Compared before the increment, so the abort lands with cycle_count == TIMEOUT_CYCLES.
          else if (cycle_count == TIMEOUT_VAL) begin
            timed_out <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
`endif
          else if (cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + CNT_ONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          start <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
